// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched sources, fixed lowest-index priority, claim/complete handshake.
// Define INTC_SYNC_EN to pass each source through a 2-flop synchronizer before edge detection.
module int_ctrl #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    input  logic [2:0]      addr,
    input  logic [31:0]     wdata,
    input  logic            we,
    input  logic            re,
    output logic [31:0]     rdata,
    output logic            ack,
    output logic            irq
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PEND    = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [1:0]      state;
    logic [1:0]      next_state;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] enable;
    logic [4:0]      claim_id;
    logic [NSRC-1:0] sampled;
    logic [NSRC-1:0] edge_reg;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] active;
    logic [NSRC-1:0] clr_mask;
    logic [NSRC-1:0] claim_mask;
    logic [4:0]      win_idx;
    logic            win_hit;
    logic            claim_hit;
    logic            complete_hit;
    logic            unused_wdata;

`ifdef INTC_SYNC_EN
    logic [NSRC-1:0] sync1;
    logic [NSRC-1:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= src;
            sync2 <= sync1;
        end
    end

    assign sampled = sync2;
`else
    assign sampled = src;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) edge_reg <= '0;
        else     edge_reg <= sampled;
    end

    assign rise   = sampled & ~edge_reg;
    assign active = pending & enable;

    // Scan downwards so the lowest active index is the last one written.
    always_comb begin
        win_hit = 1'b0;
        win_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_hit = 1'b1;
                win_idx = i[4:0];
            end
        end
    end

    assign claim_hit    = re && (addr == 3'd2) && (state == PEND) && win_hit;
    assign complete_hit = we && (addr == 3'd3) && (state == SERVICE) && (wdata[4:0] == claim_id);
    assign claim_mask   = claim_hit ? ({{(NSRC-1){1'b0}}, 1'b1} << win_idx) : '0;
    assign clr_mask     = claim_mask | ((we && (addr == 3'd0)) ? wdata[NSRC-1:0] : '0);
    assign unused_wdata = ^wdata;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|active) next_state = PEND;
            PEND: begin
                if (claim_hit)      next_state = SERVICE;
                else if (~|active)  next_state = IDLE;
            end
            SERVICE: if (complete_hit) next_state = (|active) ? PEND : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A new edge is OR'd in after the clear so a same-cycle set always survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            irq      <= 1'b0;
            pending  <= '0;
            enable   <= '0;
            claim_id <= '0;
        end else begin
            state   <= next_state;
            irq     <= (next_state == PEND);
            pending <= (pending & ~clr_mask) | rise;
            if (we && (addr == 3'd1))
                enable <= wdata[NSRC-1:0];
            if (claim_hit)
                claim_id <= win_idx + 5'd1;
            else if (complete_hit)
                claim_id <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack <= we | re;
            if (re) begin
                case (addr)
                    3'd0:    rdata <= {{(32-NSRC){1'b0}}, pending};
                    3'd1:    rdata <= {{(32-NSRC){1'b0}}, enable};
                    3'd2:    rdata <= claim_hit ? {27'd0, win_idx + 5'd1} : 32'd0;
                    3'd4:    rdata <= {19'd0, claim_id, 6'd0, state};
                    default: rdata <= 32'd0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl; expected latencies follow INTC_SYNC_EN when the bench is built with it.
module tb_int_ctrl;

`ifdef INTC_SYNC_EN
    localparam int LAT_P   = 3;
    localparam int LAT_IRQ = 4;
`else
    localparam int LAT_P   = 1;
    localparam int LAT_IRQ = 2;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  src;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        ack;
    logic        irq;

    int checks;
    int errors;

    int_ctrl #(.NSRC(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .src   (src),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .re    (re),
        .rdata (rdata),
        .ack   (ack),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bus tasks start and end on a falling edge.
    task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0; wdata = '0;
        checkOutput("ack_wr", {31'd0, ack}, 32'd1);
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
        re = 1'b1; addr = a;
        @(negedge clk);
        re = 1'b0;
        checkOutput("ack_rd", {31'd0, ack}, 32'd1);
        d = rdata;
    endtask

    task automatic wait_irq(output int n);
        n = 99;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (irq) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        int          lat;
        checks = 0;
        errors = 0;
        rst = 1'b1; src = '0; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
        tick(2);
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);
        checkOutput("rst_ack", {31'd0, ack}, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        tick(1);

        read_reg(3'd4, d);  checkOutput("status_init", d, 32'd0);
        read_reg(3'd1, d);  checkOutput("enable_init", d, 32'd0);
        read_reg(3'd2, d);  checkOutput("claim_idle", d, 32'd0);

        // Basic path with latency measurement on source 0
        write_reg(3'd1, 32'h01);
        src[0] = 1'b1;
        wait_irq(lat);
        checkOutput("latency", lat, LAT_IRQ);
        read_reg(3'd0, d);  checkOutput("basic_pending", d, 32'h01);
        read_reg(3'd4, d);  checkOutput("basic_status_pend", d, 32'h001);
        read_reg(3'd2, d);  checkOutput("basic_claim", d, 32'd1);
        checkOutput("basic_irq_drop", {31'd0, irq}, 32'd0);
        read_reg(3'd4, d);  checkOutput("basic_status_svc", d, 32'h102);
        read_reg(3'd0, d);  checkOutput("held_src_once", d, 32'h00);
        write_reg(3'd3, 32'd1);
        read_reg(3'd4, d);  checkOutput("basic_status_done", d, 32'h000);
        checkOutput("basic_irq_done", {31'd0, irq}, 32'd0);
        src[0] = 1'b0;

        // Priority between simultaneous sources 5 and 2
        write_reg(3'd1, 32'hFF);
        src[5] = 1'b1; src[2] = 1'b1;
        wait_irq(lat);
        checkOutput("prio_latency", lat, LAT_IRQ);
        src[5] = 1'b0; src[2] = 1'b0;
        read_reg(3'd2, d);  checkOutput("prio_claim1", d, 32'd3);
        checkOutput("prio_irq_drop", {31'd0, irq}, 32'd0);
        read_reg(3'd0, d);  checkOutput("prio_pending", d, 32'h20);
        write_reg(3'd3, 32'd3);
        checkOutput("prio_irq_again", {31'd0, irq}, 32'd1);
        read_reg(3'd2, d);  checkOutput("prio_claim2", d, 32'd6);
        write_reg(3'd3, 32'd6);
        read_reg(3'd4, d);  checkOutput("prio_status", d, 32'h000);

        // Masked source and write-1-to-clear
        write_reg(3'd1, 32'h00);
        src[1] = 1'b1;
        tick(1);
        src[1] = 1'b0;
        tick(5);
        read_reg(3'd0, d);  checkOutput("mask_pending", d, 32'h02);
        checkOutput("mask_irq", {31'd0, irq}, 32'd0);
        write_reg(3'd0, 32'h02);
        read_reg(3'd0, d);  checkOutput("w1c_pending", d, 32'h00);
        write_reg(3'd1, 32'h02);
        tick(3);
        checkOutput("w1c_irq", {31'd0, irq}, 32'd0);

        // Same-cycle set and W1C on bit 0, then a wrong COMPLETE id
        write_reg(3'd1, 32'h01);
        src[0] = 1'b1;
        tick(LAT_P - 1);
        write_reg(3'd0, 32'h01);
        read_reg(3'd0, d);  checkOutput("race_pending", d, 32'h01);
        tick(2);
        checkOutput("race_irq", {31'd0, irq}, 32'd1);
        read_reg(3'd2, d);  checkOutput("race_claim", d, 32'd1);
        write_reg(3'd3, 32'd7);
        read_reg(3'd4, d);  checkOutput("bad_complete", d, 32'h102);

        // Reset during SERVICE and during a read access
        re = 1'b1; addr = 3'd4; rst = 1'b1;
        tick(1);
        checkOutput("rst_svc_ack", {31'd0, ack}, 32'd0);
        checkOutput("rst_svc_rdata", rdata, 32'd0);
        checkOutput("rst_svc_irq", {31'd0, irq}, 32'd0);
        re = 1'b0; rst = 1'b0;
        read_reg(3'd4, d);  checkOutput("rst_svc_status", d, 32'h000);
        read_reg(3'd1, d);  checkOutput("rst_svc_enable", d, 32'h00);
        tick(LAT_P + 1);
        read_reg(3'd0, d);  checkOutput("rst_held_src", d, 32'h01);

        // Unimplemented bits and addresses
        write_reg(3'd5, 32'hDEAD_BEEF);
        read_reg(3'd5, d);  checkOutput("addr5_read", d, 32'd0);
        read_reg(3'd7, d);  checkOutput("addr7_read", d, 32'd0);
        write_reg(3'd1, 32'hFFFF_FFFF);
        read_reg(3'd1, d);  checkOutput("enable_upper", d, 32'hFF);

        // Disabling sources while PEND drops back to IDLE and keeps pending
        tick(2);
        checkOutput("pend_irq", {31'd0, irq}, 32'd1);
        write_reg(3'd1, 32'h00);
        tick(2);
        checkOutput("disable_irq", {31'd0, irq}, 32'd0);
        read_reg(3'd4, d);  checkOutput("disable_status", d, 32'h000);
        read_reg(3'd0, d);  checkOutput("disable_pending", d, 32'h01);
        src = '0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter NSRC, default 8, number of interrupt sources (1..31); source 0 is the timer interrupt.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 src  input  NSRC  interrupt request lines from peripherals; rising edges are latched.
REQ-005 addr  input  3  word address of the register being accessed.
REQ-006 wdata  input  32  write data.
REQ-007 we  input  1  write strobe, one cycle per access.
REQ-008 re  input  1  read strobe, one cycle per access; we and re are never both high.
REQ-009 rdata  output  32  read data, registered.
REQ-010 ack  output  1  one-cycle pulse one clock after we or re.
REQ-011 irq  output  1  interrupt request to the CPU, registered.

Function
REQ-012 Register map: addr 0 PENDING, read or write-1-to-clear; addr 1 ENABLE, read/write; addr 2 CLAIM, read-only; addr 3 COMPLETE, write-only; addr 4 STATUS, read-only; addr 5-7 read 0, writes ignored.
REQ-013 Only bits [NSRC-1:0] are implemented; upper bits read 0 and writes to them are ignored.
REQ-014 Edge detect: pending[i] sets on the cycle after sampled src[i] goes 0->1; a held-high source sets pending only once.
REQ-015 If a set and a clear (W1C or claim) hit the same bit in the same cycle, the set wins.
REQ-016 Priority: the lowest index i with pending[i] & enable[i] wins.
REQ-017 FSM states: IDLE, PEND, SERVICE.
REQ-018 IDLE->PEND when (pending & enable) != 0.
REQ-019 PEND->IDLE when (pending & enable) becomes 0 with no claim.
REQ-020 PEND->SERVICE on a CLAIM read.
REQ-021 SERVICE->IDLE or PEND on a COMPLETE write with wdata[4:0] equal to the claimed id; any other value is ignored.
REQ-022 irq is 1 exactly while the state is PEND, registered from the next-state value; irq is 0 in SERVICE, so nesting is not supported.
REQ-023 CLAIM read in PEND: rdata = winning index + 1; clears that pending bit; stores the id in claim_id.
REQ-024 CLAIM read in IDLE or SERVICE: rdata = 0 and no state change.
REQ-025 STATUS read: rdata[1:0] = state (IDLE=0, PEND=1, SERVICE=2); rdata[12:8] = claim_id (0 if none).
REQ-026 Writing ENABLE to 0 while in PEND causes PEND->IDLE on the next cycle; pending bits are kept.
REQ-027 Read latency is 1 cycle: rdata is valid while ack=1 and is held until the next read.

Reset
REQ-028 When rst=1: state=IDLE; pending, enable, claim_id, rdata = 0; irq=0; ack=0; synchronizer and edge registers = 0.
REQ-029 Reset asserted during SERVICE or during an access aborts it; no ack is issued for that access.

Configuration
REQ-030 Macro INTC_SYNC_EN defined: each src bit passes through a 2-flop synchronizer before edge detection, giving 3 cycles from src rise to pending set.
REQ-031 Macro INTC_SYNC_EN undefined: src is sampled directly by the edge register, giving 1 cycle from src rise to pending set; sources are assumed to be clk-synchronous.

Verification
REQ-032 Basic path: enable=0x01, src[0] pulses -> pending=0x01, irq=1; CLAIM read returns 1, irq=0 the next cycle; COMPLETE write of 1 -> state IDLE.
REQ-033 Priority: enable=0xFF, src[5] and src[2] rise in the same cycle -> CLAIM returns 3, then after COMPLETE 3, irq reasserts and CLAIM returns 6.
REQ-034 Masking and W1C: enable=0x00, src[1] rises -> pending=0x02, irq=0; write PENDING=0x02 -> pending=0; enable=0x02 -> irq stays 0.
REQ-035 Race: W1C of bit 0 in the same cycle that src[0] sets it -> pending[0]=1; a COMPLETE write of 7 while claimed id is 1 -> state stays SERVICE.
REQ-036 Reset: rst asserted mid-SERVICE -> all outputs 0, STATUS reads 0; a held-high src after reset sets pending again.
REQ-037 Latency: sweep both settings of INTC_SYNC_EN and check src-rise-to-irq latency is 4 cycles (defined) and 2 cycles (undefined).
